paddle_input_ctrl: RTL and testbench

Parametrised multi-paddle controller driven by PS/2 scan codes from the existing PS2 decoder (code/valid pair). It supports any number of paddles and per-paddle key maps, including extended (E0-prefixed) keys. It adds clamped motion, optional hold-acceleration, freeze and recentre controls. Sits between the PS2 decoder and the game/VGA logic; outputs packed paddle Y positions.

---
 rtl/paddle_input_ctrl_if.sv | 21 ++
 rtl/paddle_input_ctrl.sv | 116 +++++++++++
 tb/tb_paddle_input_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/paddle_input_ctrl_if.sv
// paddle_input_ctrl_if: scan-code input and paddle output bundle for paddle_input_ctrl
//   code/valid     : PS/2 decoder byte and level-high valid (new byte on rising edge)
//   freeze         : hold all positions, key tracking continues
//   recentre       : load the start position into every paddle
//   paddle_pos     : packed positions, slice i = paddle i
//   key_held       : bit 2i = up held, bit 2i+1 = down held
//   tick           : one-cycle motion tick
interface paddle_input_ctrl_if #(
    parameter int NUM_PADDLES = 2,
    parameter int POS_W = 9
);
    logic [7:0] code;
    logic valid;
    logic freeze;
    logic recentre;
    logic [NUM_PADDLES*POS_W-1:0] paddle_pos;
    logic [2*NUM_PADDLES-1:0] key_held;
    logic tick;
    modport master (output code, valid, freeze, recentre, input paddle_pos, key_held, tick);
    modport slave (input code, valid, freeze, recentre, output paddle_pos, key_held, tick);
endinterface

// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: PS/2 scan codes to clamped multi-paddle positions with optional hold-acceleration
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : paddle_input_ctrl_if.slave (code/valid/freeze/recentre in, paddle_pos/key_held/tick out)
module paddle_input_ctrl #(
    parameter int NUM_PADDLES = 2,
    parameter int SCREEN_HEIGHT = 480,
    parameter int PADDLE_LENGTH = 40,
    parameter int FRAME_WIDTH = 10,
    parameter int BOTTOM_POS = SCREEN_HEIGHT - PADDLE_LENGTH - FRAME_WIDTH,
    parameter int START_POS = (SCREEN_HEIGHT - PADDLE_LENGTH) / 2,
    parameter int POS_W = $clog2(BOTTOM_POS + 1),
    parameter int MOTION_STEP = 10,
    parameter int ACCEL_EN = 0,
    parameter int MAX_STEP = 20,
    parameter int TICK_COUNT = 500000,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter logic [9*NUM_PADDLES-1:0] KEY_UP = {9'h044, 9'h01D},
    parameter logic [9*NUM_PADDLES-1:0] KEY_DOWN = {9'h04B, 9'h01B}
) (
    input logic clk,
    input logic rst,
    paddle_input_ctrl_if.slave bus
);
    localparam int STEP_W = $clog2((MAX_STEP > MOTION_STEP ? MAX_STEP : MOTION_STEP) + 1);
    localparam int TK_W = $clog2(TICK_COUNT + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    typedef logic [POS_W:0] wide_t;
    localparam wide_t TOP = wide_t'(FRAME_WIDTH);
    localparam wide_t BOT = wide_t'(BOTTOM_POS);
    localparam logic [STEP_W-1:0] BASE_STEP = STEP_W'(MOTION_STEP);
    localparam logic [STEP_W-1:0] TOP_STEP = STEP_W'(MAX_STEP);
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    state_t state;
    logic valid_q;
    logic [TO_W-1:0] to_cnt;
    logic [TK_W-1:0] tk_cnt;
    logic [2*NUM_PADDLES-1:0] held;
    logic [POS_W-1:0] pos [NUM_PADDLES];
    logic [STEP_W-1:0] step [NUM_PADDLES];
    logic [POS_W-1:0] nxt_up [NUM_PADDLES];
    logic [POS_W-1:0] nxt_dn [NUM_PADDLES];
    logic [NUM_PADDLES-1:0] one;
    logic acc, ev, make, tick;
    logic [8:0] key;
    // Prefix bytes (F0/E0) only steer the FSM; every other accepted byte is a key event.
    always_comb begin
        acc = bus.valid && !valid_q;
        ev = acc && !(state == IDLE && (bus.code == 8'hF0 || bus.code == 8'hE0))
                 && !(state == EXT && bus.code == 8'hF0);
        make = state == IDLE || state == EXT;
        key = {state == EXT || state == EXT_BRK, bus.code};
        tick = tk_cnt == TK_W'(TICK_COUNT - 1);
    end
    // Clamp comparisons run one bit wider so pos+step never wraps.
    always_comb begin
        one = '0;
        for (int i = 0; i < NUM_PADDLES; i++) begin
            one[i] = held[2*i] ^ held[2*i+1];
            nxt_up[i] = (wide_t'(pos[i]) >= TOP + wide_t'(step[i])) ? pos[i] - POS_W'(step[i]) : POS_W'(FRAME_WIDTH);
            nxt_dn[i] = (wide_t'(pos[i]) + wide_t'(step[i]) <= BOT) ? POS_W'(wide_t'(pos[i]) + wide_t'(step[i])) : POS_W'(BOTTOM_POS);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            to_cnt <= '0;
            valid_q <= 1'b0;
            held <= '0;
        end else begin
            valid_q <= bus.valid;
            if (acc) begin
                to_cnt <= '0;
                state <= (state == IDLE && bus.code == 8'hF0) ? BRK :
                         (state == IDLE && bus.code == 8'hE0) ? EXT :
                         (state == EXT && bus.code == 8'hF0) ? EXT_BRK : IDLE;
            end else if (state == IDLE || to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state <= IDLE;
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            for (int i = 0; i < NUM_PADDLES; i++) begin
                if (ev && KEY_UP[9*i +: 9] == key) held[2*i] <= make;
                if (ev && KEY_DOWN[9*i +: 9] == key) held[2*i+1] <= make;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tk_cnt <= '0;
            for (int i = 0; i < NUM_PADDLES; i++) begin
                pos[i] <= POS_W'(START_POS);
                step[i] <= BASE_STEP;
            end
        end else begin
            tk_cnt <= tick ? '0 : tk_cnt + 1'b1;
            for (int i = 0; i < NUM_PADDLES; i++) begin
                if (bus.recentre) begin
                    pos[i] <= POS_W'(START_POS);
                    step[i] <= BASE_STEP;
                end else begin
                    if (tick && !bus.freeze && one[i]) pos[i] <= held[2*i] ? nxt_up[i] : nxt_dn[i];
                    // The move above uses the current step; acceleration takes effect next tick.
                    if (!one[i]) step[i] <= BASE_STEP;
                    else if (ACCEL_EN != 0 && tick && !bus.freeze) step[i] <= (step[i] >= TOP_STEP) ? TOP_STEP : step[i] + 1'b1;
                end
            end
        end
    end
    for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_pack
        assign bus.paddle_pos[g*POS_W +: POS_W] = pos[g];
    end
    assign bus.key_held = held;
    assign bus.tick = tick;
endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb_paddle_input_ctrl: directed vectors for paddle_input_ctrl (plain and accelerated/extended-key builds)
module tb_paddle_input_ctrl;
    typedef struct {
        int nb;
        logic [31:0] b;
        int ticks;
        logic [3:0] held;
        int p0;
        int p1;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0;
    logic freeze = 1'b1;
    logic recentre = 1'b0;
    logic sel = 1'b0;
    logic [7:0] code = 8'h00;
    logic [3:0] kh;
    logic [8:0] p0, p1;
    logic tk;
    int checks = 0;
    int errors = 0;
    vec_t va [9];
    vec_t vb [8];
    always #5 clk = ~clk;
    paddle_input_ctrl_if #(.NUM_PADDLES(2), .POS_W(9)) bus_a ();
    paddle_input_ctrl_if #(.NUM_PADDLES(2), .POS_W(9)) bus_b ();
    assign {bus_a.code, bus_a.valid, bus_a.freeze, bus_a.recentre} = {code, valid, freeze, recentre};
    assign {bus_b.code, bus_b.valid, bus_b.freeze, bus_b.recentre} = {code, valid, freeze, recentre};
    paddle_input_ctrl #(.TICK_COUNT(4), .TIMEOUT_CYCLES(16)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    paddle_input_ctrl #(.TICK_COUNT(4), .TIMEOUT_CYCLES(16), .ACCEL_EN(1), .MAX_STEP(12),
                        .KEY_UP({9'h044, 9'h175})) u_b (.clk(clk), .rst(rst), .bus(bus_b));
    assign kh = sel ? bus_b.key_held : bus_a.key_held;
    assign {p1, p0} = sel ? bus_b.paddle_pos : bus_a.paddle_pos;
    assign tk = sel ? bus_b.tick : bus_a.tick;
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        code = b;
        valid = 1'b1;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
    endtask
    task automatic run_ticks(input int n);
        int c = 0;
        int g = 0;
        freeze = 1'b0;
        while (c < n && g < n * 8 + 16) begin
            if (tk) c++;
            @(negedge clk);
            g++;
        end
        freeze = 1'b1;
        chk("tick_budget", c, n);
    endtask
    task automatic run_vec(input vec_t v, input string tag, input int idx);
        for (int i = 0; i < v.nb; i++) send(v.b[31-8*i -: 8]);
        chk($sformatf("%s%0d_held", tag, idx), int'(kh), int'(v.held));
        if (v.ticks > 0) run_ticks(v.ticks);
        chk($sformatf("%s%0d_p0", tag, idx), int'(p0), v.p0);
        chk($sformatf("%s%0d_p1", tag, idx), int'(p1), v.p1);
    endtask
    initial begin
        va[0] = '{1, 32'h1D000000, 3, 4'b0001, 190, 220};
        va[1] = '{2, 32'hF01D0000, 2, 4'b0000, 190, 220};
        va[2] = '{1, 32'h4B000000, 2, 4'b1000, 190, 240};
        va[3] = '{2, 32'h1D1B0000, 1, 4'b1011, 190, 250};
        va[4] = '{2, 32'hF01B0000, 18, 4'b1001, 10, 430};
        va[5] = '{2, 32'hF04B0000, 2, 4'b0001, 10, 430};
        va[6] = '{3, 32'hE0F01D00, 1, 4'b0001, 10, 430};
        va[7] = '{3, 32'hF01D1B00, 40, 4'b0010, 410, 430};
        va[8] = '{1, 32'h12000000, 0, 4'b0010, 410, 430};
        vb[0] = '{1, 32'h75000000, 0, 4'b0000, 220, 220};
        vb[1] = '{2, 32'hE0750000, 0, 4'b0001, 220, 220};
        vb[2] = '{3, 32'hE0F07500, 0, 4'b0000, 220, 220};
        vb[3] = '{1, 32'h1B000000, 4, 4'b0010, 265, 220};
        vb[4] = '{2, 32'hF01B0000, 0, 4'b0000, 265, 220};
        vb[5] = '{1, 32'h1B000000, 1, 4'b0010, 275, 220};
        vb[6] = '{4, 32'hF01BE075, 24, 4'b0001, 10, 220};
        vb[7] = '{4, 32'hE0F0751B, 37, 4'b0010, 430, 220};
        repeat (2) @(negedge clk);
        chk("rst_held", int'(kh), 0);
        chk("rst_p0", int'(p0), 220);
        chk("rst_p1", int'(p1), 220);
        chk("rst_tick", int'(tk), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("tick_early", int'(tk), 0);
        @(negedge clk);
        chk("tick_first", int'(tk), 1);
        for (int i = 0; i < 9; i++) run_vec(va[i], "a", i);
        send(8'hF0);
        send(8'h1B);
        chk("a_brk_1b", int'(kh), 0);
        send(8'hF0);
        repeat (20) @(negedge clk);
        send(8'h1B);
        chk("a_timeout_make", int'(kh), 4'b0010);
        run_ticks(1);
        chk("a_timeout_move", int'(p0), 420);
        repeat (12) @(negedge clk);
        chk("a_freeze", int'(p0), 420);
        send(8'hF0);
        recentre = 1'b1;
        @(negedge clk);
        recentre = 1'b0;
        chk("a_recentre_p0", int'(p0), 220);
        chk("a_recentre_p1", int'(p1), 220);
        chk("a_recentre_held", int'(kh), 4'b0010);
        send(8'h1B);
        chk("a_brk_after_recentre", int'(kh), 0);
        rst = 1'b1;
        sel = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("b_rst_p0", int'(p0), 220);
        for (int i = 0; i < 8; i++) run_vec(vb[i], "b", i);
        recentre = 1'b1;
        @(negedge clk);
        recentre = 1'b0;
        chk("b_recentre_p0", int'(p0), 220);
        chk("b_recentre_p1", int'(p1), 220);
        chk("b_recentre_held", int'(kh), 4'b0010);
        run_ticks(1);
        chk("b_step_after_recentre", int'(p0), 230);
        freeze = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("b_async_rst_p0", int'(p0), 220);
        chk("b_async_rst_held", int'(kh), 0);
        chk("b_async_rst_tick", int'(tk), 0);
        @(negedge clk);
        rst = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
